// File: rtl/eco_vec_driver_pkg.sv
// Purpose     : shared types, limits and golden function for the ECO NOR vector driver.
// Latency     : n/a (declarations only).
// Backpressure: n/a.
// Contents    : eco_state_e run-state encoding, ECO_SETTLE_MAX, eco_nor_golden().
package eco_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FINISH = 2'd3
    } eco_state_e;

    // Longest settle wait supported; the wait counter is sized to hold it.
    localparam int ECO_SETTLE_MAX = 15;
    localparam int ECO_WCNT_W     = 4;

    // Widest operand the golden function handles; callers zero-extend and
    // truncate the result back to their own width.
    localparam int ECO_GOLDEN_W = 32;

    function automatic logic [ECO_GOLDEN_W-1:0] eco_nor_golden(
        input logic [ECO_GOLDEN_W-1:0] a,
        input logic [ECO_GOLDEN_W-1:0] b
    );
        return ~(a | b);
    endfunction

endpackage

// File: rtl/eco_vec_driver_if.sv
// Purpose     : operand/result bus between the vector driver and the block under test.
// Latency     : none; plain wires.
// Backpressure: none; the block under test is combinational.
// Signals     : a_out, b_out (driver -> block), y_in (block -> driver); master = driver side.
interface eco_vec_driver_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [WIDTH-1:0] y_in;

    modport master (output a_out, output b_out, input y_in);
    modport slave  (input a_out, input b_out, output y_in);
endinterface

// File: rtl/eco_vec_driver_nor_ref.sv
// Purpose     : combinational golden NOR model, y = ~(a | b).
// Latency     : 0 cycles.
// Backpressure: none.
// Ports       : a, b (WIDTH operands in), y (WIDTH result out).
module eco_nor_ref
    import eco_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = WIDTH'(eco_nor_golden(ECO_GOLDEN_W'(a), ECO_GOLDEN_W'(b)));

endmodule

// File: rtl/eco_vec_driver.sv
// Purpose     : exhaustive NOR self-check driver; walks all {a,b} vectors and counts mismatches.
// Latency     : done pulses 2^(2*WIDTH)*(SETTLE+1)+1 cycles after the start edge.
// Backpressure: none; start is only sampled in IDLE and ignored while a run is in progress.
// Ports       : clk, rst_n (async active-low), start; bus (master: a_out, b_out, y_in);
//               busy, done, pass, err_cnt[2W:0], first_fail[2W-1:0].
// Config      : ECO_FIRST_FAIL_EN defined keeps the first_fail capture register,
//               otherwise first_fail is tied to zero.
module eco_vec_driver
    import eco_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int SETTLE = 1    // 0..ECO_SETTLE_MAX
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    eco_vec_driver_if.master     bus,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_cnt,
    output logic [2*WIDTH-1:0]   first_fail
);

    localparam int VEC_W = 2 * WIDTH;
    localparam int ERR_W = 2 * WIDTH + 1;

    eco_state_e              state, state_n;
    logic [ECO_WCNT_W-1:0]   wcnt, wcnt_n;
    logic [VEC_W-1:0]        vec, vec_n;
    logic                    run_start;
    logic                    check_en;
    logic                    last_vec;
    logic                    mismatch;
    logic [WIDTH-1:0]        golden;
    logic [ERR_W-1:0]        err_cnt_upd;

    // Operands come straight from the vector register, so they hold steady
    // for the whole vector and keep the last vector after the run.
    assign bus.a_out = vec[VEC_W-1:WIDTH];
    assign bus.b_out = vec[WIDTH-1:0];

    eco_nor_ref #(.WIDTH(WIDTH)) u_ref (
        .a (bus.a_out),
        .b (bus.b_out),
        .y (golden)
    );

    assign mismatch    = check_en && (bus.y_in != golden);
    assign err_cnt_upd = mismatch ? (err_cnt + ERR_W'(1)) : err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            wcnt  <= '0;
            vec   <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            vec   <= vec_n;
        end
    end

    always_comb begin
        state_n   = state;
        wcnt_n    = wcnt;
        vec_n     = vec;
        run_start = 1'b0;
        check_en  = 1'b0;
        last_vec  = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    run_start = 1'b1;
                    vec_n     = '0;
                    if (SETTLE == 0) begin
                        state_n = ST_CHECK;
                    end else begin
                        state_n = ST_WAIT;
                        wcnt_n  = ECO_WCNT_W'(SETTLE);
                    end
                end
            end
            ST_WAIT: begin
                // Entered with the counter at SETTLE, so exactly SETTLE WAIT cycles.
                wcnt_n = wcnt - ECO_WCNT_W'(1);
                if (wcnt <= ECO_WCNT_W'(1)) begin
                    state_n = ST_CHECK;
                end
            end
            ST_CHECK: begin
                check_en = 1'b1;
                if (&vec) begin
                    last_vec = 1'b1;
                    state_n  = ST_FINISH;
                end else begin
                    vec_n = vec + VEC_W'(1);
                    if (SETTLE == 0) begin
                        state_n = ST_CHECK;
                    end else begin
                        state_n = ST_WAIT;
                        wcnt_n  = ECO_WCNT_W'(SETTLE);
                    end
                end
            end
            ST_FINISH: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Result registers. pass is loaded on the edge leaving the last CHECK so it
    // is already valid in the cycle that done is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            pass    <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (run_start) begin
                busy    <= 1'b1;
                pass    <= 1'b0;
                err_cnt <= '0;
            end else begin
                err_cnt <= err_cnt_upd;
                if (last_vec) begin
                    busy <= 1'b0;
                    pass <= (err_cnt_upd == '0);
                end
            end
        end
    end

`ifdef ECO_FIRST_FAIL_EN
    logic [VEC_W-1:0] first_fail_q;

    // err_cnt still zero means this is the first mismatch of the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_q <= '0;
        end else if (run_start) begin
            first_fail_q <= '0;
        end else if (mismatch && (err_cnt == '0)) begin
            first_fail_q <= vec;
        end
    end

    assign first_fail = first_fail_q;
`else
    assign first_fail = '0;
`endif

endmodule

// File: tb/tb_eco_vec_driver.sv
module tb_eco_vec_driver;

    typedef struct {
        int dut;
        int cyc;
        int err;
        int pass;
        int ff;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] start_v = 3'b000;
    logic [2:0] busy_v, done_v, pass_v;
    logic [6:0] err_v [3];
    logic [5:0] ff_v  [3];
    logic [2:0] a_v   [3];
    logic [2:0] b_v   [3];
    int         mode = 0;   // 0 ideal NOR, 1 y[0] stuck 0, 2 NAND, 3 slow NOR (3-cycle delay, dut2 only)
    int         cyc = 0;
    int         done_cnt = 0;
    int         errors = 0;
    int         checks = 0;
    exp_t       sb[$];

`ifdef ECO_FIRST_FAIL_EN
    localparam int NAND_FF = 1;
`else
    localparam int NAND_FF = 0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eco_vec_driver_if #(.WIDTH(3)) bif0 ();
    eco_vec_driver_if #(.WIDTH(3)) bif1 ();
    eco_vec_driver_if #(.WIDTH(3)) bif2 ();

    eco_vec_driver #(.WIDTH(3), .SETTLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .bus(bif0),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_cnt(err_v[0]), .first_fail(ff_v[0])
    );
    eco_vec_driver #(.WIDTH(3), .SETTLE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .bus(bif1),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_cnt(err_v[1]), .first_fail(ff_v[1])
    );
    eco_vec_driver #(.WIDTH(3), .SETTLE(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .bus(bif2),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .err_cnt(err_v[2]), .first_fail(ff_v[2])
    );

    assign a_v[0] = bif0.a_out;  assign b_v[0] = bif0.b_out;
    assign a_v[1] = bif1.a_out;  assign b_v[1] = bif1.b_out;
    assign a_v[2] = bif2.a_out;  assign b_v[2] = bif2.b_out;

    // Blocks under test.
    function automatic logic [2:0] blk(input int m, input logic [2:0] a, input logic [2:0] b);
        case (m)
            1:       return ~(a | b) & 3'b110;
            2:       return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction

    logic [2:0] d1, d2, d3;
    always @(posedge clk) begin
        d1 <= ~(bif2.a_out | bif2.b_out);
        d2 <= d1;
        d3 <= d2;
    end

    assign bif0.y_in = blk(mode, bif0.a_out, bif0.b_out);
    assign bif1.y_in = blk(mode, bif1.a_out, bif1.b_out);
    assign bif2.y_in = (mode == 3) ? d3 : blk(mode, bif2.a_out, bif2.b_out);

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboard monitor: every done pulse pops one expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_v[i]) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk($sformatf("unexpected_done_dut%0d", i), 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_dut", i, e.dut);
                    chk("done_cycle", cyc, e.cyc);
                    chk("err_cnt", int'(err_v[i]), e.err);
                    chk("pass", int'(pass_v[i]), e.pass);
                    chk("first_fail", int'(ff_v[i]), e.ff);
                    chk("busy_at_done", int'(busy_v[i]), 0);
                end
            end
        end
    end

    task automatic run(input int d, input int m, input int lat, input int err,
                       input int p, input int ff, input int repulse);
        exp_t e;
        int   cyc0;
        int   n0;
        @(negedge clk);
        mode = m;
        cyc0 = cyc;
        n0   = done_cnt;
        e.dut = d; e.cyc = cyc0 + lat; e.err = err; e.pass = p; e.ff = ff;
        sb.push_back(e);
        start_v[d] = 1'b1;
        while (done_cnt == n0 && cyc < cyc0 + lat + 20) begin
            @(negedge clk);
            if (repulse != 0 && cyc == cyc0 + repulse) begin
                chk("busy_mid_run", int'(busy_v[d]), 1);
                start_v[d] = 1'b1;
            end else begin
                start_v[d] = 1'b0;
            end
        end
        start_v[d] = 1'b0;
        if (done_cnt == n0) begin
            chk("done_timeout", 0, 1);
            void'(sb.pop_front());
        end
        repeat (3) @(negedge clk);
        chk("pass_held", int'(pass_v[d]), p);
        chk("a_hold_last", int'(a_v[d]), 7);
        chk("b_hold_last", int'(b_v[d]), 7);
    endtask

    initial begin
        exp_t e;
        int   cyc0;
        int   n0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy_v[0]), 0);
        chk("rst_done", int'(done_v[0]), 0);
        chk("rst_pass", int'(pass_v[0]), 0);
        chk("rst_err", int'(err_v[0]), 0);
        chk("rst_ff", int'(ff_v[0]), 0);
        chk("rst_a", int'(a_v[0]), 0);
        chk("rst_b", int'(b_v[0]), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ideal, stuck bit, NAND substitution, restart ignored + counters cleared
        run(0, 0, 129, 0,  1, 0,       0);
        run(0, 1, 129, 16, 0, 0,       0);
        run(0, 2, 129, 56, 0, NAND_FF, 0);
        run(0, 0, 129, 0,  1, 0,       40);

        // Reset mid-run: everything returns to zero and no done follows
        @(negedge clk);
        mode = 1;
        cyc0 = cyc;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        while (cyc < cyc0 + 50) @(negedge clk);
        chk("mid_run_busy", int'(busy_v[0]), 1);
        chk("mid_run_err_nonzero", int'(err_v[0] != 0), 1);
        n0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy_v[0]), 0);
        chk("abort_a", int'(a_v[0]), 0);
        chk("abort_b", int'(b_v[0]), 0);
        chk("abort_err", int'(err_v[0]), 0);
        chk("abort_pass", int'(pass_v[0]), 0);
        chk("abort_done", int'(done_v[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        chk("no_done_after_abort", done_cnt, n0);
        run(0, 0, 129, 0, 1, 0, 0);

        // SETTLE = 0, then start held high: back-to-back runs
        run(1, 0, 65, 0, 1, 0, 0);
        @(negedge clk);
        mode = 1;
        cyc0 = cyc;
        n0   = done_cnt;
        e.dut = 1; e.err = 16; e.pass = 0; e.ff = 0;
        e.cyc = cyc0 + 65;  sb.push_back(e);
        e.cyc = cyc0 + 131; sb.push_back(e);
        start_v[1] = 1'b1;
        while (cyc < cyc0 + 70) @(negedge clk);
        start_v[1] = 1'b0;
        while (done_cnt < n0 + 2 && cyc < cyc0 + 170) @(negedge clk);
        chk("held_start_two_runs", done_cnt - n0, 2);
        while (sb.size() > 0) void'(sb.pop_front());

        // SETTLE = 3: slow block settles only by the CHECK cycle
        run(2, 3, 257, 0,  1, 0, 0);
        run(2, 1, 257, 16, 0, 0, 0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eco_vec_driver.md
# eco_vec_driver

Self-checking stimulus driver for the bitwise-NOR netlist blocks used in our ECO flow. On `start`, it walks every combination of the two WIDTH-bit operands and drives each one to the block under test. After each vector it samples the block's output and compares it against the golden `~(a | b)`. It sits in the ECO test harness on the initiator side of the combinational netlist, and reports pass/fail, mismatch count and the first failing vector.

## Interface
- `WIDTH`, default 3: bit width of each operand and of the result.
- `SETTLE`, default 1, legal 0..15: wait cycles between driving a vector and the check cycle.
- `clk`  in  1  single clock; everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `a_out`  out  WIDTH  operand a driven to the block under test.
- `b_out`  out  WIDTH  operand b driven to the block under test.
- `y_in`  in  WIDTH  result returned by the block under test.
- `busy`  out  1  high from the accepted start through the last CHECK.
- `done`  out  1  one-cycle pulse when the run completes.
- `pass`  out  1  high when the last completed run had zero mismatches; held until the next start.
- `err_cnt`  out  2*WIDTH+1  number of mismatching vectors in the current or last run.
- `first_fail`  out  2*WIDTH  {a,b} of the first mismatching vector.

## Operation
- Reset values: all outputs 0; state IDLE; vector counter 0.
- The vector counter `vec` is 2*WIDTH bits wide. `a_out` = `vec[2W-1:W]`, `b_out` = `vec[W-1:0]`. Both are registered and stable for the whole vector.
- State IDLE:
  - If `start` = 1, clear `err_cnt`, `pass` and `first_fail`, set `vec` = 0, and set `busy` = 1.
  - Go to WAIT with wait counter = SETTLE. If SETTLE = 0, go directly to CHECK.
- State WAIT: decrement the wait counter each cycle. When the counter reaches 1, go to CHECK.
- State CHECK: compare `y_in` against `~(a_out | b_out)`.
  - On any bit mismatch, increment `err_cnt`. If this is the first mismatch, load `first_fail` = `vec`.
  - If `vec` is all ones, go to FINISH. Otherwise increment `vec` and go to WAIT (or to CHECK if SETTLE = 0).
- State FINISH:
  - `busy` = 0, `done` = 1 for exactly this cycle, `pass` = (`err_cnt` == 0).
  - Return to IDLE.
  - `a_out` and `b_out` keep their last vector.
- `start` is ignored outside IDLE. If `start` is held high, a new run is accepted in the IDLE cycle that follows FINISH.
- `err_cnt` never wraps: its width holds the full 2^(2W) vector count.
- `rst_n` asserted mid-run aborts the run immediately and returns every output to its reset value. No `done` pulse is produced.

## Timing
- Each vector takes SETTLE+1 cycles: SETTLE WAIT cycles plus 1 CHECK cycle. `y_in` is sampled on the edge that ends CHECK.
- Let the start edge be t. `done` is high in cycle t + 2^(2W)·(SETTLE+1) + 1.
  - Defaults (WIDTH=3, SETTLE=1): 129.
- `y_in` is treated as combinational from `a_out`/`b_out`. The block under test must settle within SETTLE+1 cycles.

## Configuration
- `ECO_FIRST_FAIL_EN`:
  - Defined: the `first_fail` capture register is present, as described above.
  - Undefined: the register is removed and `first_fail` is tied to 0. All other behaviour is unchanged.

## Structure
- Package `eco_pkg` holds:
  - the state encoding (IDLE, WAIT, CHECK, FINISH);
  - the `ECO_SETTLE_MAX` = 15 constant;
  - the golden function `eco_nor_golden(a, b)`.
- One sub-module, `eco_nor_ref`: a parameterised WIDTH combinational golden model producing `~(a | b)`. It is instantiated once and its output is compared against `y_in`.

## Test plan
- Ideal NOR loopback (`y_in` = `~(a_out|b_out)`), defaults, one `start` pulse -> `done` at cycle 129, `pass` = 1, `err_cnt` = 0, `first_fail` = 0.
- `y_in[0]` stuck at 0 -> 16 mismatches (vectors with `a[0]` = `b[0]` = 0) -> `err_cnt` = 16, `pass` = 0, `first_fail` = 6'b000000.
- NAND substituted (`y_in` = `~(a_out&b_out)`) -> mismatch on every vector with a != b -> `err_cnt` = 56, `first_fail` = 6'b000001.
- `start` pulsed again at cycle 40 of a run -> ignored, `done` still at 129. A second run with ideal loopback after a failing run clears the counters -> `err_cnt` = 0, `pass` = 1.
- `rst_n` low at cycle 50 -> `busy`, `a_out`, `b_out`, `err_cnt` and `pass` all 0 asynchronously, with no `done` pulse. A following `start` gives a complete clean run.
- SETTLE = 0 -> `done` at cycle 65. SETTLE = 3 -> `done` at cycle 257, with `y_in` sampled only in the CHECK cycle.
